// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Purpose : bundles the raster timing signals exchanged between the timing
//           generator and its consumers (shape generators, VGA output stage).
// Signals : ce          - pixel enable, driven by the consumer side
//           hcount[10:0] - current pixel column
//           vcount[9:0]  - current line
//           hsync/vsync - sync pulses at their configured polarity
//           blank       - high outside the visible area
//           line_start  - one-clock pulse when hcount wraps to 0
//           frame_start - one-clock pulse when (hcount,vcount) wraps to (0,0)
// Modports: master - the timing generator (drives timing, samples ce)
//           slave  - a timing consumer (drives ce, samples timing)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic        ce;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  ce,
    output hcount,
    output vcount,
    output hsync,
    output vsync,
    output blank,
    output line_start,
    output frame_start
  );

  modport slave (
    output ce,
    input  hcount,
    input  vcount,
    input  hsync,
    input  vsync,
    input  blank,
    input  line_start,
    input  frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Purpose : free-running raster timing generator for one display mode
//           (default XGA 1024x768@60, 65 MHz pixel clock).
// Ports   : clk   - pixel clock, all logic on its rising edge
//           reset - synchronous, active-high; restarts the raster at (0,0)
//           vga   - vga_timing_gen_if.master: ce in; hcount, vcount, hsync,
//                   vsync, blank, line_start, frame_start out (all registered)
// Notes   : sync/blank are decoded from the *next* count values so that the
//           registered flags line up with the registered counts in the same
//           cycle. Axis phase (active/fp/sync/bp) is implied by the count
//           ranges; no separate state register is kept.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 1024,
  parameter int   H_FP      = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BP      = 160,
  parameter int   V_ACTIVE  = 768,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BP      = 29,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  vga_timing_gen_if.master   vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Totals must be representable by the 11-bit / 10-bit counters.
  generate
    if ((H_TOTAL < 1) || (H_TOTAL > 2048)) begin : g_h_total_chk
      $error("vga_timing_gen: H_TOTAL does not fit an 11-bit hcount");
    end
    if ((V_TOTAL < 1) || (V_TOTAL > 1024)) begin : g_v_total_chk
      $error("vga_timing_gen: V_TOTAL does not fit a 10-bit vcount");
    end
  endgenerate

  localparam logic [10:0] H_LAST_C   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_C    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG_C   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END_C   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST_C   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG_C   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END_C   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank;
  logic        r_line_start;
  logic        r_frame_start;

  logic [10:0] w_hcount_nxt;
  logic [9:0]  w_vcount_nxt;
  logic        w_line_nxt;
  logic        w_frame_nxt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_hsync_act;
  logic        w_vsync_act;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;
  logic        w_blank_nxt;

  assign w_h_wrap = (r_hcount == H_LAST_C);
  assign w_v_wrap = (r_vcount == V_LAST_C);

  // Next-count and pulse computation; vertical only steps on a horizontal wrap.
  always_comb begin
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    w_line_nxt   = 1'b0;
    w_frame_nxt  = 1'b0;
    if (vga.ce) begin
      if (w_h_wrap) begin
        w_hcount_nxt = 11'd0;
        w_line_nxt   = 1'b1;
        if (w_v_wrap) begin
          w_vcount_nxt = 10'd0;
          w_frame_nxt  = 1'b1;
        end else begin
          w_vcount_nxt = r_vcount + 10'd1;
        end
      end else begin
        w_hcount_nxt = r_hcount + 11'd1;
      end
    end else begin
      w_hcount_nxt = r_hcount;
      w_vcount_nxt = r_vcount;
    end
  end

  // Sync/blank decode from the next counts so flags align with the counts.
  always_comb begin
    w_hsync_act = (w_hcount_nxt >= HS_BEG_C) && (w_hcount_nxt < HS_END_C);
    w_vsync_act = (w_vcount_nxt >= VS_BEG_C) && (w_vcount_nxt < VS_END_C);
    w_hsync_nxt = w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
    w_vsync_nxt = w_vsync_act ? VSYNC_POL : ~VSYNC_POL;
    w_blank_nxt = (w_hcount_nxt >= H_ACT_C) || (w_vcount_nxt >= V_ACT_C);
  end

  // Output registers; reset restarts at (0,0) without emitting pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 10'd0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_blank       <= w_blank_nxt;
      r_line_start  <= w_line_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

  assign vga.hcount      = r_hcount;
  assign vga.vcount      = r_vcount;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.blank       = r_blank;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule
